// File: rtl/alu_pc.sv
// 8-bit 6502-style ALU with registered result/flags, plus an independent 16-bit program counter.
// Both blocks share one clock and one asynchronous active-low reset.

module alu_pc_core (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [4:0] mode,
   input  logic       cin,
   output logic [7:0] res,
   output logic       c,
   output logic       v
);
   localparam logic [4:0] M_ADD   = 5'd0;
   localparam logic [4:0] M_SUB   = 5'd1;
   localparam logic [4:0] M_AND   = 5'd2;
   localparam logic [4:0] M_OR    = 5'd3;
   localparam logic [4:0] M_EOR   = 5'd4;
   localparam logic [4:0] M_ASL   = 5'd5;
   localparam logic [4:0] M_LSR   = 5'd6;
   localparam logic [4:0] M_ROL   = 5'd7;
   localparam logic [4:0] M_ROR   = 5'd8;
   localparam logic [4:0] M_INC   = 5'd9;
   localparam logic [4:0] M_DEC   = 5'd10;
   localparam logic [4:0] M_PASSB = 5'd11;

   logic [7:0] op_b;
   logic [8:0] sum;

   // SUB shares the adder using the 6502 borrow convention: A + ~B + C.
   assign op_b = (mode == M_SUB) ? ~b : b;
   assign sum  = {1'b0, a} + {1'b0, op_b} + {8'h00, cin};

   always_comb begin
      res = a;
      c   = 1'b0;
      v   = 1'b0;
      case (mode)
         M_ADD: begin
            {c, res} = sum;
            v = (a[7] == b[7]) && (sum[7] != a[7]);
         end
         M_SUB: begin
            {c, res} = sum;
            v = (a[7] != b[7]) && (sum[7] != a[7]);
         end
         M_AND:   res = a & b;
         M_OR:    res = a | b;
         M_EOR:   res = a ^ b;
         M_ASL:   {c, res} = {a, 1'b0};
         M_LSR:   {res, c} = {1'b0, a};
         M_ROL:   {c, res} = {a, cin};
         M_ROR:   {res, c} = {cin, a};
         M_INC:   res = a + 8'd1;
         M_DEC:   res = a - 8'd1;
         M_PASSB: res = b;
         default: res = a;
      endcase
   end
endmodule

module alu_pc #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  alu_a,
   input  logic [7:0]  alu_b,
   input  logic [4:0]  mode,
   input  logic        carry_in,
   output logic [7:0]  alu_out,
   output logic        carry_out,
   output logic        overflow,
   output logic        zero,
   output logic        sign,
   input  logic [15:0] pc_in,
   input  logic        pc_load,
   input  logic        pc_inc,
   output logic [15:0] pc_out
);
   typedef struct packed {
      logic [7:0] res;
      logic       c;
      logic       v;
      logic       z;
      logic       n;
   } alu_rsp_t;

   alu_rsp_t   nxt, q;
   logic [7:0] core_res;
   logic       core_c, core_v;

   alu_pc_core u_core (
      .a    (alu_a),
      .b    (alu_b),
      .mode (mode),
      .cin  (carry_in),
      .res  (core_res),
      .c    (core_c),
      .v    (core_v)
   );

   always_comb begin
      nxt.res = core_res;
      nxt.c   = core_c;
      nxt.v   = core_v;
      nxt.z   = (core_res == 8'h00);
      nxt.n   = core_res[7];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= '0;
      else      q <= nxt;
   end

   // Load beats increment; increment wraps silently at 16'hFFFF.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         pc_out <= RESET_PC;
      else if (pc_load) pc_out <= pc_in;
      else if (pc_inc)  pc_out <= pc_out + 16'd1;
   end

   assign alu_out   = q.res;
   assign carry_out = q.c;
   assign overflow  = q.v;
   assign zero      = q.z;
   assign sign      = q.n;
endmodule

// File: tb/tb_alu_pc.sv
// Directed-vector bench for alu_pc: ALU modes, flags, PC load/inc/wrap, async reset.
module tb_alu_pc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  alu_a = '0, alu_b = '0;
   logic [4:0]  mode = '0;
   logic        carry_in = 1'b0;
   logic [7:0]  alu_out;
   logic        carry_out, overflow, zero, sign;
   logic [15:0] pc_in = '0;
   logic        pc_load = 1'b0, pc_inc = 1'b0;
   logic [15:0] pc_out;

   int n_cmp = 0;
   int n_err = 0;

   alu_pc #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .alu_a(alu_a), .alu_b(alu_b), .mode(mode),
      .carry_in(carry_in), .alu_out(alu_out), .carry_out(carry_out),
      .overflow(overflow), .zero(zero), .sign(sign), .pc_in(pc_in),
      .pc_load(pc_load), .pc_inc(pc_inc), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // flags packed as {C,V,Z,N}
   task automatic alu_vec(input string tag, input logic [4:0] m, input logic [7:0] a,
                          input logic [7:0] b, input logic ci,
                          input logic [7:0] er, input logic [3:0] ef);
      mode = m; alu_a = a; alu_b = b; carry_in = ci;
      cyc();
      chk({tag, ".res"}, {24'h0, alu_out}, {24'h0, er});
      chk({tag, ".cvzn"}, {28'h0, carry_out, overflow, zero, sign}, {28'h0, ef});
   endtask

   initial begin
      #2 rst = 1'b0;
      #1;
      chk("rst.alu", {24'h0, alu_out}, 32'h0);
      chk("rst.flags", {28'h0, carry_out, overflow, zero, sign}, 32'h0);
      chk("rst.pc", {16'h0, pc_out}, 32'h0);
      #6 rst = 1'b1;
      #1;

      //       tag      mode   A      B      cin  result C V Z N
      alu_vec("add_v",  5'd0,  8'h50, 8'h50, 1'b0, 8'hA0, 4'b0101);
      alu_vec("add_c",  5'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010);
      alu_vec("add_ci", 5'd0,  8'h01, 8'h01, 1'b1, 8'h03, 4'b0000);
      alu_vec("sub_b",  5'd1,  8'h00, 8'h01, 1'b1, 8'hFF, 4'b0001);
      alu_vec("sub_z",  5'd1,  8'h05, 8'h05, 1'b1, 8'h00, 4'b1010);
      alu_vec("sub_v",  5'd1,  8'h80, 8'h01, 1'b1, 8'h7F, 4'b1100);
      alu_vec("and",    5'd2,  8'hF0, 8'h0F, 1'b1, 8'h00, 4'b0010);
      alu_vec("or",     5'd3,  8'hA0, 8'h05, 1'b0, 8'hA5, 4'b0001);
      alu_vec("eor",    5'd4,  8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0010);
      alu_vec("asl",    5'd5,  8'h81, 8'h00, 1'b0, 8'h02, 4'b1000);
      alu_vec("lsr",    5'd6,  8'h01, 8'h00, 1'b1, 8'h00, 4'b1010);
      alu_vec("rol",    5'd7,  8'h80, 8'h00, 1'b0, 8'h00, 4'b1010);
      alu_vec("rol_ci", 5'd7,  8'h40, 8'h00, 1'b1, 8'h81, 4'b0001);
      alu_vec("ror",    5'd8,  8'h01, 8'h00, 1'b1, 8'h80, 4'b1001);
      alu_vec("inc",    5'd9,  8'hFF, 8'h00, 1'b1, 8'h00, 4'b0010);
      alu_vec("dec",    5'd10, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b0001);
      alu_vec("passb",  5'd11, 8'h12, 8'h7F, 1'b1, 8'h7F, 4'b0000);
      alu_vec("m12",    5'd12, 8'h33, 8'hFF, 1'b1, 8'h33, 4'b0000);
      alu_vec("m31",    5'd31, 8'h9C, 8'h00, 1'b1, 8'h9C, 4'b0001);

      // PC: load, increment across the wrap, priority, hold
      pc_load = 1'b1; pc_in = 16'hFFFE;
      cyc();
      chk("pc_load", {16'h0, pc_out}, 32'h0000FFFE);
      pc_load = 1'b0; pc_inc = 1'b1;
      cyc();
      chk("pc_inc1", {16'h0, pc_out}, 32'h0000FFFF);
      cyc();
      chk("pc_wrap", {16'h0, pc_out}, 32'h00000000);
      pc_load = 1'b1; pc_in = 16'h1234;
      cyc();
      chk("pc_prio", {16'h0, pc_out}, 32'h00001234);
      pc_load = 1'b0; pc_inc = 1'b0; pc_in = 16'hAAAA;
      cyc();
      chk("pc_hold", {16'h0, pc_out}, 32'h00001234);
      chk("alu_indep", {24'h0, alu_out}, 32'h0000009C);

      // async reset mid-cycle with live ALU result and pc=1234
      mode = 5'd0; alu_a = 8'h50; alu_b = 8'h50; carry_in = 1'b0;
      cyc();
      chk("pre_rst.alu", {24'h0, alu_out}, 32'h000000A0);
      #2 rst = 1'b0;
      #1;
      chk("arst.alu", {24'h0, alu_out}, 32'h0);
      chk("arst.flags", {28'h0, carry_out, overflow, zero, sign}, 32'h0);
      chk("arst.pc", {16'h0, pc_out}, 32'h0);
      pc_load = 1'b1; pc_in = 16'h5555;
      cyc();
      chk("hold_rst.alu", {24'h0, alu_out}, 32'h0);
      chk("hold_rst.pc", {16'h0, pc_out}, 32'h0);
      #2 rst = 1'b1;
      mode = 5'd11; alu_b = 8'h80;
      cyc();
      chk("post_rst.alu", {24'h0, alu_out}, 32'h00000080);
      chk("post_rst.flags", {28'h0, carry_out, overflow, zero, sign}, 32'h00000001);
      chk("post_rst.pc", {16'h0, pc_out}, 32'h00005555);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
